// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver.
// Synchronizes the asynchronous ps2_clk/ps2_data pins, detects ps2_clk falling
// edges, assembles an 11-bit frame (start, d0..d7, odd parity, stop) and
// presents each correctly received byte with a one-cycle out_valid pulse.
// A partial frame is abandoned after TIMEOUT_CYCLES clk cycles without a
// ps2_clk falling edge.
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] output_data,
  output logic       out_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_prev;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo_cnt;

  logic w_fall;
  logic w_bit;
  logic w_frame_ok;
  logic w_timeout;

  // Equal-depth synchronizers for both pins plus the previous-clock flop used
  // for edge detection; all preset high so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would collapse the chain.
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  // Falling edge: synchronized ps2_clk was 1 last cycle and is 0 now. Data is
  // taken from the same pipeline stage, so it is aligned with the edge.
  assign w_fall     = r_clk_prev & ~r_clk_sync[1];
  assign w_bit      = r_data_sync[1];
  // Stop bit is the bit sampled on this (final) edge; odd parity over d7..d0+p.
  assign w_frame_ok = w_bit & (^r_shift ^ r_parity);
  assign w_timeout  = (r_state != S_IDLE) && !w_fall &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Frame FSM, shift register, timeout counter and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_tmo_cnt   <= '0;
      output_data <= 8'h00;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (r_state == S_IDLE || w_fall) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + TW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_bit) begin
            r_state   <= S_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift[r_bit_cnt] <= w_bit;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_parity <= w_bit;
            r_state  <= S_STOP;
          end
        end
        default: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (w_frame_ok) begin
              output_data <= r_shift;
              out_valid   <= 1'b1;
            end
          end
        end
      endcase

      // NOTE: placed after the case so this later non-blocking assignment to
      // r_state wins; the timeout therefore overrides any FSM transition.
      if (w_timeout) r_state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: frames are driven on the PS/2 pins,
// bytes that must be accepted are queued, and a monitor pops and compares on
// every out_valid pulse.
`timescale 1ns/100ps
module tb_ps2_receiver;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] output_data;
  logic       out_valid;

  int n_checks = 0;
  int n_fails  = 0;
  int n_pushed = 0;
  int n_pulses = 0;
  logic [7:0] sb[$];
  logic prev_valid = 1'b0;

  ps2_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .output_data(output_data),
    .out_valid  (out_valid)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest queued byte and last one cycle.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_pulses++;
      if (sb.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else                check("rx_byte", {24'd0, output_data}, {24'd0, sb.pop_front()});
      check("pulse_width", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = out_valid;
  end

  // Drive nbits of a frame; queue the byte only for a complete, valid frame.
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                            input int half, input int nbits);
    logic [10:0] bits;
    bits = {stop_ok ? 1'b1 : 1'b0, par_ok ? ~^d : ^d, d, 1'b0};
    if (nbits == 11 && par_ok && stop_ok) begin
      sb.push_back(d);
      n_pushed++;
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      #(half);
      ps2_clk = 1'b0;
      #(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Bounded wait for the scoreboard to empty; expiry shows as a failed check.
  task automatic wait_drain(input string tag, input int max_ns);
    for (int t = 0; t < max_ns && sb.size() != 0; t++) #1;
    check(tag, sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #10;
    check("rst_data", {24'd0, output_data}, 32'h0);
    check("rst_valid", {31'd0, out_valid}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #0.5;
    do_reset();
    #10;

    // Basic frame at fast ps2 clock; output within 10 ns of last rising edge.
    send_frame(8'hA5, 1'b1, 1'b1, 5, 11);
    wait_drain("a5_latency", 10);
    check("a5_hold", {24'd0, output_data}, 32'hA5);
    #40;

    // Good 0x3C, then bad parity and bad stop frames are rejected.
    send_frame(8'h3C, 1'b1, 1'b1, 10, 11);
    wait_drain("3c_drain", 20);
    #40;
    send_frame(8'hA5, 1'b0, 1'b1, 10, 11);
    #60;
    check("bad_parity_hold", {24'd0, output_data}, 32'h3C);
    send_frame(8'h77, 1'b1, 1'b0, 10, 11);
    #60;
    check("bad_stop_hold", {24'd0, output_data}, 32'h3C);

    // Back-to-back frames with only the stop-to-start gap.
    send_frame(8'h00, 1'b1, 1'b1, 10, 11);
    send_frame(8'hFF, 1'b1, 1'b1, 10, 11);
    wait_drain("b2b_drain", 20);
    check("b2b_last", {24'd0, output_data}, 32'hFF);
    #40;

    // Reset mid-frame, then a fresh frame.
    send_frame(8'h99, 1'b1, 1'b1, 10, 5);
    do_reset();
    #20;
    send_frame(8'h3C, 1'b1, 1'b1, 10, 11);
    wait_drain("post_reset_drain", 20);
    check("post_reset_data", {24'd0, output_data}, 32'h3C);
    #40;

    // Stray falling edge with data high in IDLE is ignored.
    ps2_data = 1'b1;
    #10 ps2_clk = 1'b0;
    #10 ps2_clk = 1'b1;
    #40;
    send_frame(8'h5A, 1'b1, 1'b1, 10, 11);
    wait_drain("stray_drain", 20);
    check("stray_data", {24'd0, output_data}, 32'h5A);
    #40;

    // Partial frame abandoned by timeout, then a normal frame.
    send_frame(8'hC3, 1'b1, 1'b1, 10, 4);
    #(2 * TMO * 2);
    send_frame(8'h12, 1'b1, 1'b1, 10, 11);
    wait_drain("timeout_drain", 20);
    check("timeout_data", {24'd0, output_data}, 32'h12);

    // Output holds with no further activity.
    #200;
    check("idle_hold", {24'd0, output_data}, 32'h12);
    check("pulse_count", n_pulses, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
